prbs31_burst_ctrl: RTL and testbench

Sequencer for a PRBS31 generator (x^31 + x^28 + 1). It seeds the LFSR, emits a programmed number of bursts of programmed length separated by idle gaps, and flags burst boundaries. It sits between the top-level pin wrapper, which supplies config/start/stop, and the serial output pins. The LFSR is a sub-module that this block loads and steps.

---
 rtl/prbs31_burst_ctrl_pkg.sv | 28 ++
 rtl/prbs31_burst_ctrl_if.sv | 53 +++++
 rtl/prbs31_burst_ctrl_lfsr.sv | 45 ++++
 rtl/prbs31_burst_ctrl.sv | 187 ++++++++++++++++++
 tb/tb_prbs31_burst_ctrl.sv | 241 ++++++++++++++++++++++++
 5 files changed

// File: rtl/prbs31_burst_ctrl_pkg.sv
// prbs_pkg: shared definitions for the PRBS31 burst sequencer.
//   - state_t      : controller states (IDLE, LOAD, BURST, GAP, DONE)
//   - PRBS31_WIDTH : LFSR width
//   - TAP_HI/TAP_LO: feedback taps for x^31 + x^28 + 1
//   - SEED_DEFAULT : reset value and replacement for an all-zero seed
//   - fix_seed()   : maps the illegal all-zero seed onto SEED_DEFAULT
// Optional build macro used elsewhere in this slice: PRBS_ERRINJ_EN.
package prbs_pkg;

  localparam int PRBS31_WIDTH = 31;
  localparam int TAP_HI       = 30;
  localparam int TAP_LO       = 27;
  localparam logic [PRBS31_WIDTH-1:0] SEED_DEFAULT = 31'd1;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LOAD  = 3'd1,
    BURST = 3'd2,
    GAP   = 3'd3,
    DONE  = 3'd4
  } state_t;

  // An all-zero LFSR is a lock-up state, so a zero seed is never loaded.
  function automatic logic [PRBS31_WIDTH-1:0] fix_seed(input logic [PRBS31_WIDTH-1:0] seed);
    return (seed == '0) ? SEED_DEFAULT : seed;
  endfunction

endpackage

// File: rtl/prbs31_burst_ctrl_if.sv
// prbs31_burst_ctrl_if: control/config and serial-output bundle of the
// PRBS31 burst sequencer.
//   master modport: pin wrapper side (drives start/stop/cfg_*, observes outputs)
//   slave  modport: sequencer side   (observes start/stop/cfg_*, drives outputs)
// Signals: start, stop, cfg_seed[30:0], cfg_len[LEN_W], cfg_gap[GAP_W],
//          cfg_bursts[LEN_W], cfg_reseed, prbs_bit, bit_valid, sob, eob,
//          busy, done, aborted.
// With PRBS_ERRINJ_EN defined: errinj (to sequencer) and err_cnt[7:0].
interface prbs31_burst_ctrl_if #(
  parameter int LEN_W = 16,
  parameter int GAP_W = 8
);

  logic             start;
  logic             stop;
  logic [30:0]      cfg_seed;
  logic [LEN_W-1:0] cfg_len;
  logic [GAP_W-1:0] cfg_gap;
  logic [LEN_W-1:0] cfg_bursts;
  logic             cfg_reseed;

  logic             prbs_bit;
  logic             bit_valid;
  logic             sob;
  logic             eob;
  logic             busy;
  logic             done;
  logic             aborted;

`ifdef PRBS_ERRINJ_EN
  logic             errinj;
  logic [7:0]       err_cnt;
`endif

  modport master (
    output start, stop, cfg_seed, cfg_len, cfg_gap, cfg_bursts, cfg_reseed,
`ifdef PRBS_ERRINJ_EN
    output errinj,
    input  err_cnt,
`endif
    input  prbs_bit, bit_valid, sob, eob, busy, done, aborted
  );

  modport slave (
    input  start, stop, cfg_seed, cfg_len, cfg_gap, cfg_bursts, cfg_reseed,
`ifdef PRBS_ERRINJ_EN
    input  errinj,
    output err_cnt,
`endif
    output prbs_bit, bit_valid, sob, eob, busy, done, aborted
  );

endinterface

// File: rtl/prbs31_burst_ctrl_lfsr.sv
// prbs31_lfsr: bare 31-bit Fibonacci shift register for x^31 + x^28 + 1.
// Holds state only; all sequencing lives in the controller.
// Ports:
//   clk, rst_n (async, active-low) -- reset loads SEED_DEFAULT
//   load      -- load seed (priority over step)
//   seed      -- value to load
//   step      -- advance one position: {s[29:0], s[30]^s[27]}
//   state_out -- current register contents; state_out[30] is the output bit
module prbs31_lfsr
  import prbs_pkg::*;
(
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    load,
  input  logic [PRBS31_WIDTH-1:0] seed,
  input  logic                    step,
  output logic [PRBS31_WIDTH-1:0] state_out
);

  logic [PRBS31_WIDTH-1:0] lfsr_reg;
  logic [PRBS31_WIDTH-1:0] lfsr_next;

  // Shift toward the MSB; feedback enters at bit 0.
  assign lfsr_next[0] = lfsr_reg[TAP_HI] ^ lfsr_reg[TAP_LO];

  genvar gi;
  generate
    for (gi = 1; gi < PRBS31_WIDTH; gi++) begin : g_shift
      assign lfsr_next[gi] = lfsr_reg[gi-1];
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lfsr_reg <= SEED_DEFAULT;
    end else if (load) begin
      lfsr_reg <= seed;
    end else if (step) begin
      lfsr_reg <= lfsr_next;
    end
  end

  assign state_out = lfsr_reg;

endmodule

// File: rtl/prbs31_burst_ctrl.sv
// prbs31_burst_ctrl: sequencer around a PRBS31 LFSR. On start it latches the
// configuration, seeds the LFSR, and emits cfg_bursts bursts of cfg_len bits
// separated by cfg_gap idle cycles, flagging the first (sob) and last (eob)
// bit of each burst.
// Ports:
//   clk   -- clock
//   rst_n -- asynchronous active-low reset
//   bus   -- prbs31_burst_ctrl_if.slave: start/stop/cfg_* in,
//            prbs_bit/bit_valid/sob/eob/busy/done/aborted out
// Encoding of zero in config: cfg_len=0 -> 2^LEN_W bits, cfg_gap=0 ->
// back-to-back bursts, cfg_bursts=0 -> run until stop, cfg_seed=0 -> 1.
// Build macro PRBS_ERRINJ_EN adds errinj (inverts prbs_bit for that BURST
// cycle) and a saturating 8-bit err_cnt cleared on start.
module prbs31_burst_ctrl
  import prbs_pkg::*;
#(
  parameter int LEN_W = 16,
  parameter int GAP_W = 8
)(
  input  logic                 clk,
  input  logic                 rst_n,
  prbs31_burst_ctrl_if.slave   bus
);

  state_t state_reg, state_next;

  // Configuration shadows, captured only when start is accepted.
  logic [PRBS31_WIDTH-1:0] seed_sh;
  logic [LEN_W-1:0]        len_sh;
  logic [GAP_W-1:0]        gap_sh;
  logic [LEN_W-1:0]        bursts_sh;
  logic                    reseed_sh;

  // Down-counters: bit_rem counts remaining bits after the current one,
  // gap_rem remaining gap cycles after the current one, burst_rem bursts left.
  logic [LEN_W-1:0]        bit_rem;
  logic [GAP_W-1:0]        gap_rem;
  logic [LEN_W-1:0]        burst_rem;
  logic                    aborted_reg;

  logic                    start_ok;
  logic                    last_bit;
  logic                    last_burst;
  logic                    gap_last;
  logic [LEN_W-1:0]        len_m1;
  logic [GAP_W-1:0]        gap_m1;

  logic                    lfsr_load;
  logic                    lfsr_step;
  logic [PRBS31_WIDTH-1:0] lfsr_state;
  logic                    unused_lfsr_bits;
  logic                    inj;

  // len_sh = 0 wraps to all-ones, giving exactly 2^LEN_W bits.
  assign len_m1     = len_sh - LEN_W'(1);
  assign gap_m1     = gap_sh - GAP_W'(1);
  assign start_ok   = (state_reg == IDLE) && bus.start && !bus.stop;
  assign last_bit   = (bit_rem == '0);
  // A zero burst count means continuous: the terminal condition never fires.
  assign last_burst = (bursts_sh != '0) && (burst_rem == LEN_W'(1));
  assign gap_last   = (gap_rem == '0);

  // ---------------------------------------------------------------- state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    unique case (state_reg)
      IDLE:  if (start_ok) state_next = LOAD;
      LOAD:  state_next = BURST;
      BURST: begin
        if (last_bit) begin
          if (last_burst)         state_next = DONE;
          else if (gap_sh != '0)  state_next = GAP;
          else if (reseed_sh)     state_next = LOAD;
          else                    state_next = BURST;
        end
      end
      GAP:   if (gap_last) state_next = reseed_sh ? LOAD : BURST;
      DONE:  state_next = IDLE;
      default: state_next = IDLE;
    endcase
    // Abort overrides everything outside IDLE. In DONE the done pulse is
    // already visible, so this only shortens nothing and raises no abort.
    if (bus.stop && (state_reg != IDLE)) begin
      state_next = IDLE;
    end
  end

  // ------------------------------------------------------- config + counters
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      seed_sh     <= '0;
      len_sh      <= '0;
      gap_sh      <= '0;
      bursts_sh   <= '0;
      reseed_sh   <= 1'b0;
      bit_rem     <= '0;
      gap_rem     <= '0;
      burst_rem   <= '0;
      aborted_reg <= 1'b0;
    end else begin
      aborted_reg <= bus.stop &&
                     ((state_reg == LOAD) || (state_reg == BURST) || (state_reg == GAP));
      unique case (state_reg)
        IDLE: begin
          if (start_ok) begin
            seed_sh   <= fix_seed(bus.cfg_seed);
            len_sh    <= bus.cfg_len;
            gap_sh    <= bus.cfg_gap;
            bursts_sh <= bus.cfg_bursts;
            reseed_sh <= bus.cfg_reseed;
            burst_rem <= bus.cfg_bursts;
          end
        end
        // Any state that can precede BURST pre-loads the bit counter.
        LOAD, GAP: begin
          bit_rem <= len_m1;
          if (state_reg == GAP) gap_rem <= gap_rem - GAP_W'(1);
        end
        BURST: begin
          gap_rem <= gap_m1;
          if (last_bit) begin
            bit_rem <= len_m1;
            if (bursts_sh != '0) burst_rem <= burst_rem - LEN_W'(1);
          end else begin
            bit_rem <= bit_rem - LEN_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

  // -------------------------------------------------------------- LFSR
  assign lfsr_load = (state_reg == LOAD);
  assign lfsr_step = (state_reg == BURST);

  prbs31_lfsr u_lfsr (
    .clk       (clk),
    .rst_n     (rst_n),
    .load      (lfsr_load),
    .seed      (seed_sh),
    .step      (lfsr_step),
    .state_out (lfsr_state)
  );

  // Only the MSB is observed externally.
  assign unused_lfsr_bits = ^lfsr_state[TAP_HI-1:0];

  // ---------------------------------------------------------- error inject
`ifdef PRBS_ERRINJ_EN
  logic [7:0] err_cnt_reg;

  assign inj = bus.errinj && (state_reg == BURST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_cnt_reg <= '0;
    end else if (start_ok) begin
      err_cnt_reg <= '0;
    end else if (inj && (err_cnt_reg != 8'hFF)) begin
      err_cnt_reg <= err_cnt_reg + 8'd1;
    end
  end

  assign bus.err_cnt = err_cnt_reg;
`else
  assign inj = 1'b0;
`endif

  // -------------------------------------------------------------- outputs
  assign bus.bit_valid = (state_reg == BURST);
  assign bus.prbs_bit  = (state_reg == BURST) && (lfsr_state[TAP_HI] ^ inj);
  assign bus.sob       = (state_reg == BURST) && (bit_rem == len_m1);
  assign bus.eob       = (state_reg == BURST) && last_bit;
  assign bus.busy      = (state_reg != IDLE);
  assign bus.done      = (state_reg == DONE);
  assign bus.aborted   = aborted_reg;

endmodule

// File: tb/tb_prbs31_burst_ctrl.sv
// Scoreboard bench for prbs31_burst_ctrl. Each run pushes a time-stamped
// list of expected output vectors {bit_valid, prbs_bit, sob, eob, done,
// aborted}; a negedge monitor pops and compares, and flags any output that
// appears when nothing is expected. The reference PRBS comes from the
// sequence recurrence b[n] = b[n-31] ^ b[n-28] with b[0..30] = seed[30..0].
module tb_prbs31_burst_ctrl;

  localparam int LEN_W = 16;
  localparam int GAP_W = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  prbs31_burst_ctrl_if #(.LEN_W(LEN_W), .GAP_W(GAP_W)) bus_if ();

  prbs31_burst_ctrl #(.LEN_W(LEN_W), .GAP_W(GAP_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_if.slave)
  );

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int         cyc;
    logic [5:0] v;
  } exp_t;

  exp_t q[$];
  int   n_tests = 0;
  int   n_fail  = 0;
  bit   ref_bits[];

  function automatic logic [5:0] outs();
    return {bus_if.bit_valid, bus_if.prbs_bit, bus_if.sob, bus_if.eob,
            bus_if.done, bus_if.aborted};
  endfunction

  // ------------------------------------------------------------- monitor
  always @(negedge clk) begin
    logic [5:0] act;
    act = outs();
    while (q.size() > 0 && q[0].cyc < cyc) begin
      n_tests++;
      n_fail++;
      $display("FAIL missed_output: expected %b at cycle %0d, not observed", q[0].v, q[0].cyc);
      void'(q.pop_front());
    end
    if (q.size() > 0 && q[0].cyc == cyc) begin
      n_tests++;
      if (act !== q[0].v) begin
        n_fail++;
        $display("FAIL output_vector cycle %0d: got %b, expected %b", cyc, act, q[0].v);
      end
      void'(q.pop_front());
    end else if (act !== 6'b0) begin
      n_tests++;
      n_fail++;
      $display("FAIL unexpected_output cycle %0d: got %b, expected 000000", cyc, act);
    end
  end

  // ------------------------------------------------------------- model
  task automatic gen_ref(input logic [30:0] seed, input int n);
    int sz;
    sz = (n < 31) ? 31 : n;
    ref_bits = new[sz];
    for (int k = 0; k < 31; k++) ref_bits[k] = seed[30-k];
    for (int k = 31; k < sz; k++) ref_bits[k] = ref_bits[k-31] ^ ref_bits[k-28];
  endtask

  // c0: cycle at which start was presented; stop_cyc < 0 means no abort.
  task automatic expect_run(input int c0, input logic [30:0] seed, input int len,
                            input int gap, input int bursts, input bit reseed,
                            input int stop_cyc);
    int L, period, nb, t, bidx;
    logic [30:0] s;
    s      = (seed == 31'd0) ? 31'd1 : seed;
    L      = (len == 0) ? 65536 : len;
    period = L + gap + (reseed ? 1 : 0);
    nb     = (bursts == 0) ? ((stop_cyc - c0) / period + 2) : bursts;
    gen_ref(s, nb * L);
    t = c0 + 1;
    for (int k = 0; k < nb; k++) begin
      for (int i = 0; i < L; i++) begin
        t = c0 + 2 + k * period + i;
        if (stop_cyc >= 0 && t > stop_cyc) begin
          q.push_back('{stop_cyc + 1, 6'b000001});
          return;
        end
        bidx = reseed ? i : (k * L + i);
        q.push_back('{t, {1'b1, ref_bits[bidx], (i == 0), (i == L - 1), 2'b00}});
      end
    end
    q.push_back('{t + 1, 6'b000010});
  endtask

  // ------------------------------------------------------------- helpers
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Presents a one-cycle start, then scrambles cfg to prove it was latched.
  task automatic do_start(input logic [30:0] seed, input int len, input int gap,
                          input int bursts, input bit reseed, output int c0);
    @(negedge clk);
    bus_if.cfg_seed   = seed;
    bus_if.cfg_len    = 16'(len);
    bus_if.cfg_gap    = 8'(gap);
    bus_if.cfg_bursts = 16'(bursts);
    bus_if.cfg_reseed = reseed;
    bus_if.start      = 1'b1;
    c0 = cyc;
    @(negedge clk);
    bus_if.start      = 1'b0;
    bus_if.cfg_seed   = 31'($urandom);
    bus_if.cfg_len    = 16'($urandom);
    bus_if.cfg_gap    = 8'($urandom);
    bus_if.cfg_bursts = 16'($urandom);
    bus_if.cfg_reseed = 1'($urandom);
  endtask

  task automatic drain(input string name);
    int n;
    n = 0;
    while (q.size() > 0 && n < 3000) begin
      @(negedge clk);
      #1;
      n++;
    end
    check({name, "_drained"}, 32'(q.size()), 32'd0);
    q.delete();
    @(negedge clk);
    #1;
    check({name, "_busy_low"}, 32'(bus_if.busy), 32'd0);
  endtask

  task automatic run(input string name, input logic [30:0] seed, input int len,
                     input int gap, input int bursts, input bit reseed);
    int c0;
    do_start(seed, len, gap, bursts, reseed, c0);
    expect_run(c0, seed, len, gap, bursts, reseed, -1);
    drain(name);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  // ------------------------------------------------------------- stimulus
  initial begin
    int c0, stop_cyc;
    bus_if.start = 1'b0;
    bus_if.stop = 1'b0;
    bus_if.cfg_seed = '0;
    bus_if.cfg_len = '0;
    bus_if.cfg_gap = '0;
    bus_if.cfg_bursts = '0;
    bus_if.cfg_reseed = 1'b0;

    repeat (3) @(negedge clk);
    check("reset_outputs", 32'(outs()), 32'd0);
    check("reset_busy", 32'(bus_if.busy), 32'd0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Single 32-bit burst from a seed with only the MSB set.
    run("msb_seed", 31'h4000_0000, 32, 0, 1, 1'b0);
    // Zero seed behaves as seed 1.
    run("zero_seed", 31'd0, 40, 0, 1, 1'b0);
    // Reseeded bursts with gap: spacing gap+1.
    run("reseed_gap", 31'h7FFF_FFFF, 4, 3, 3, 1'b1);

    // Back-to-back bursts continue the sequence; a start while busy is ignored.
    do_start(31'h1234_5678, 8, 0, 2, 1'b0, c0);
    expect_run(c0, 31'h1234_5678, 8, 0, 2, 1'b0, -1);
    repeat (3) @(negedge clk);
    bus_if.cfg_len = 16'd3;
    bus_if.start = 1'b1;
    @(negedge clk);
    bus_if.start = 1'b0;
    drain("contiguous");

    // Continuous mode aborted in the middle of the third burst.
    do_start(31'h0ABC_DEF1, 5, 2, 0, 1'b0, c0);
    stop_cyc = c0 + 2 + 2 * 7 + 2;
    expect_run(c0, 31'h0ABC_DEF1, 5, 2, 0, 1'b0, stop_cyc);
    while (cyc < stop_cyc) @(negedge clk);
    bus_if.stop = 1'b1;
    @(negedge clk);
    bus_if.stop = 1'b0;
    drain("abort");

    // start together with stop in IDLE is refused.
    @(negedge clk);
    bus_if.cfg_len = 16'd4;
    bus_if.cfg_bursts = 16'd1;
    bus_if.start = 1'b1;
    bus_if.stop = 1'b1;
    @(negedge clk);
    bus_if.start = 1'b0;
    bus_if.stop = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      check("start_stop_idle_busy", 32'(bus_if.busy), 32'd0);
      @(negedge clk);
    end

    // Asynchronous reset mid-burst, then a single-bit burst.
    do_start(31'h5555_AAAA, 100, 0, 1, 1'b0, c0);
    expect_run(c0, 31'h5555_AAAA, 100, 0, 1, 1'b0, -1);
    while (cyc < c0 + 10) @(negedge clk);
    #2;
    q.delete();
    rst_n = 1'b0;
    #1;
    check("async_reset_outputs", 32'(outs()), 32'd0);
    check("async_reset_busy", 32'(bus_if.busy), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    run("len_one", 31'h2468_ACE1, 1, 0, 1, 1'b0);

    // Randomized configurations.
    for (int it = 0; it < 20; it++) begin
      run("random", 31'($urandom), int'($urandom_range(1, 12)), int'($urandom_range(0, 3)),
          int'($urandom_range(1, 3)), 1'($urandom));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
